// File: rtl/ariscv_fetch_ctrl_if.sv
// Signal bundle between the fetch sequencer and instruction memory, the fetch
// datapath (PC mux / PC reg / FD reg) and the decode/execute stages.
interface ariscv_fetch_ctrl_if #(
    parameter int unsigned NBW_PC  = 32,
    parameter int unsigned NBW_CNT = 16
);
    logic               i_start;
    logic               i_halt;
    logic               o_imem_req;
    logic               i_imem_ack;
    logic               i_redirect;
    logic [NBW_PC-1:0]  i_pc_target;
    logic               o_pc_en;
    logic               o_pc_sel;
    logic [NBW_PC-1:0]  o_pc_target;
    logic               o_fd_en;
    logic               o_fd_valid;
    logic               i_fd_ready;
    logic               o_flush;
    logic               o_err_timeout;
    logic [NBW_CNT-1:0] o_fetch_cnt;

    modport slave (
        input  i_start,
        input  i_halt,
        output o_imem_req,
        input  i_imem_ack,
        input  i_redirect,
        input  i_pc_target,
        output o_pc_en,
        output o_pc_sel,
        output o_pc_target,
        output o_fd_en,
        output o_fd_valid,
        input  i_fd_ready,
        output o_flush,
        output o_err_timeout,
        output o_fetch_cnt
    );

    modport master (
        output i_start,
        output i_halt,
        input  o_imem_req,
        output i_imem_ack,
        output i_redirect,
        output i_pc_target,
        input  o_pc_en,
        input  o_pc_sel,
        input  o_pc_target,
        input  o_fd_en,
        input  o_fd_valid,
        output i_fd_ready,
        input  o_flush,
        input  o_err_timeout,
        input  o_fetch_cnt
    );
endinterface

// File: rtl/ariscv_fetch_ctrl.sv
// Fetch-stage sequencer: imem req/ack handshake, PC / FD capture enables,
// decode back-pressure and execute redirects with a latched pending target.
module ariscv_fetch_ctrl #(
    parameter int unsigned NBW_PC     = 32,
    parameter int unsigned NBW_CNT    = 16,
    parameter int unsigned TMO_CYCLES = 16
) (
    input  logic               pc_aclk,
    input  logic               rst_async_n,
    ariscv_fetch_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT_FD = 2'd2,
        ST_ERR     = 2'd3
    } state_t;

    localparam logic        TMO_EN   = (TMO_CYCLES != 32'd0);
    localparam logic [15:0] TMO_LAST = TMO_EN ? 16'(TMO_CYCLES - 32'd1) : 16'd0;

    state_t              r_state;
    state_t              w_state_nxt;
    state_t              w_after_txn;
    logic                r_imem_req;
    logic                r_fd_valid;
    logic                r_err;
    logic                r_pend;
    logic [NBW_PC-1:0]   r_tgt;
    logic [NBW_CNT-1:0]  r_fetch_cnt;
    logic [15:0]         r_tmo_cnt;

    logic                w_want_redir;
    logic                w_slot_free;
    logic                w_tmo_hit;
    logic                w_pc_en;
    logic                w_pc_sel;
    logic                w_fd_en;
    logic                w_applied;
    logic                w_new_txn;

    assign w_want_redir = r_pend | bus.i_redirect;
    assign w_slot_free  = ~r_fd_valid | bus.i_fd_ready;
    assign w_tmo_hit    = TMO_EN & (r_tmo_cnt == TMO_LAST);
    assign w_after_txn  = bus.i_halt ? ST_IDLE : ST_REQ;
    assign w_applied    = w_pc_en & w_pc_sel;
    // A fresh transaction starts whenever REQ is entered or re-entered after an ack.
    assign w_new_txn    = (w_state_nxt == ST_REQ) &
                          ((r_state != ST_REQ) | bus.i_imem_ack);

    // State register.
    always_ff @(posedge pc_aclk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_start & ~bus.i_halt) begin
                    w_state_nxt = ST_REQ;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.i_imem_ack) begin
                    if (w_want_redir | w_slot_free) begin
                        w_state_nxt = w_after_txn;
                    end else begin
                        w_state_nxt = ST_WAIT_FD;
                    end
                end else if (w_tmo_hit) begin
                    w_state_nxt = ST_ERR;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_WAIT_FD: begin
                if (w_want_redir | bus.i_fd_ready) begin
                    w_state_nxt = w_after_txn;
                end else begin
                    w_state_nxt = ST_WAIT_FD;
                end
            end
            ST_ERR: begin
                w_state_nxt = ST_ERR;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Capture-enable decode; a redirect always beats delivering an instruction.
    always_comb begin
        w_pc_en  = 1'b0;
        w_pc_sel = 1'b0;
        w_fd_en  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_want_redir) begin
                    w_pc_en  = 1'b1;
                    w_pc_sel = 1'b1;
                end else begin
                    w_pc_en  = 1'b0;
                end
            end
            ST_REQ: begin
                if (bus.i_imem_ack & w_want_redir) begin
                    w_pc_en  = 1'b1;
                    w_pc_sel = 1'b1;
                end else if (bus.i_imem_ack & w_slot_free) begin
                    w_pc_en  = 1'b1;
                    w_fd_en  = 1'b1;
                end else begin
                    w_pc_en  = 1'b0;
                end
            end
            ST_WAIT_FD: begin
                if (w_want_redir) begin
                    w_pc_en  = 1'b1;
                    w_pc_sel = 1'b1;
                end else if (bus.i_fd_ready) begin
                    w_pc_en  = 1'b1;
                    w_fd_en  = 1'b1;
                end else begin
                    w_pc_en  = 1'b0;
                end
            end
            ST_ERR: begin
                w_pc_en  = 1'b0;
            end
            default: begin
                w_pc_en  = 1'b0;
            end
        endcase
    end

    // Request and error flags are registered from the next state so they are glitch-free.
    always_ff @(posedge pc_aclk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            r_imem_req <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_imem_req <= (w_state_nxt == ST_REQ);
            r_err      <= (w_state_nxt == ST_ERR);
        end
    end

    // FD occupancy: flush beats capture, capture beats consume.
    always_ff @(posedge pc_aclk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            r_fd_valid <= 1'b0;
        end else if (bus.i_redirect) begin
            r_fd_valid <= 1'b0;
        end else if (w_fd_en) begin
            r_fd_valid <= 1'b1;
        end else if (bus.i_fd_ready) begin
            r_fd_valid <= 1'b0;
        end else begin
            r_fd_valid <= r_fd_valid;
        end
    end

    // Redirect target latch and pending flag, held until the PC register takes it.
    always_ff @(posedge pc_aclk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            r_tgt  <= '0;
            r_pend <= 1'b0;
        end else begin
            if (bus.i_redirect) begin
                r_tgt <= bus.i_pc_target;
            end else begin
                r_tgt <= r_tgt;
            end
            if (w_applied) begin
                r_pend <= 1'b0;
            end else if (bus.i_redirect) begin
                r_pend <= 1'b1;
            end else begin
                r_pend <= r_pend;
            end
        end
    end

    // Delivered-instruction counter, wraps naturally.
    always_ff @(posedge pc_aclk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            r_fetch_cnt <= '0;
        end else if (w_fd_en) begin
            r_fetch_cnt <= r_fetch_cnt + {{(NBW_CNT-1){1'b0}}, 1'b1};
        end else begin
            r_fetch_cnt <= r_fetch_cnt;
        end
    end

    // Cycles spent waiting for ack in the current transaction.
    always_ff @(posedge pc_aclk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            r_tmo_cnt <= 16'd0;
        end else if (w_new_txn) begin
            r_tmo_cnt <= 16'd0;
        end else if ((r_state == ST_REQ) & ~bus.i_imem_ack) begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end else begin
            r_tmo_cnt <= r_tmo_cnt;
        end
    end

    assign bus.o_imem_req    = r_imem_req;
    assign bus.o_pc_en       = w_pc_en;
    assign bus.o_pc_sel      = w_pc_sel;
    assign bus.o_pc_target   = bus.i_redirect ? bus.i_pc_target : r_tgt;
    assign bus.o_fd_en       = w_fd_en;
    assign bus.o_fd_valid    = r_fd_valid;
    assign bus.o_flush       = bus.i_redirect;
    assign bus.o_err_timeout = r_err;
    assign bus.o_fetch_cnt   = r_fetch_cnt;

endmodule

// File: tb/tb_ariscv_fetch_ctrl.sv
// Self-checking bench for ariscv_fetch_ctrl: directed vector table, hand-written
// timeout / async-reset sequences and randomized traffic against a transaction-level model.
module tb_ariscv_fetch_ctrl;
    localparam int unsigned NBW_PC  = 32;
    localparam int unsigned NBW_CNT = 16;
    localparam int unsigned TMO     = 16;
    localparam int          NV      = 25;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ariscv_fetch_ctrl_if #(.NBW_PC(NBW_PC), .NBW_CNT(NBW_CNT)) bus ();

    ariscv_fetch_ctrl #(
        .NBW_PC(NBW_PC),
        .NBW_CNT(NBW_CNT),
        .TMO_CYCLES(TMO)
    ) dut (
        .pc_aclk(clk),
        .rst_async_n(rst_n),
        .bus(bus)
    );

    typedef struct packed {
        logic        start;
        logic        halt;
        logic        ack;
        logic        redir;
        logic [31:0] tgt;
        logic        rdy;
    } stim_t;

    typedef struct packed {
        stim_t       s;
        logic        req;
        logic        fd_en;
        logic        pc_en;
        logic        pc_sel;
        logic        fdv;
        logic [15:0] cnt;
    } vec_t;

    int n_total = 0;
    int n_bad   = 0;
    vec_t tbl [NV];

    // Transaction-level model: is a request outstanding, is an acked instruction
    // parked waiting for FD, has the memory timed out.
    logic        m_req, m_hold, m_err, m_pend, m_fdv;
    logic [31:0] m_tgt;
    logic [15:0] m_cnt;
    int          m_wait;
    logic        e_pc_en, e_pc_sel, e_fd_en, e_flush;
    logic [31:0] e_tgt;

    function automatic stim_t mks(input logic st, input logic h, input logic a,
                                  input logic r, input logic [31:0] t, input logic rd);
        stim_t s;
        s.start = st; s.halt = h; s.ack = a; s.redir = r; s.tgt = t; s.rdy = rd;
        return s;
    endfunction

    function automatic vec_t mk(input stim_t s, input logic q, input logic fe,
                                input logic pe, input logic ps, input logic fv,
                                input logic [15:0] c);
        vec_t v;
        v.s = s; v.req = q; v.fd_en = fe; v.pc_en = pe; v.pc_sel = ps; v.fdv = fv; v.cnt = c;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_req = 1'b0; m_hold = 1'b0; m_err = 1'b0; m_pend = 1'b0; m_fdv = 1'b0;
        m_tgt = 32'd0; m_cnt = 16'd0; m_wait = 0;
    endtask

    task automatic model_comb(input stim_t s);
        logic want;
        want     = s.redir | m_pend;
        e_pc_en  = 1'b0;
        e_pc_sel = 1'b0;
        e_fd_en  = 1'b0;
        e_flush  = s.redir;
        e_tgt    = s.redir ? s.tgt : m_tgt;
        if (m_err) begin
            e_pc_en = 1'b0;
        end else if (m_req) begin
            if (s.ack && want) begin
                e_pc_en = 1'b1; e_pc_sel = 1'b1;
            end else if (s.ack && (!m_fdv || s.rdy)) begin
                e_pc_en = 1'b1; e_fd_en = 1'b1;
            end
        end else if (m_hold) begin
            if (want) begin
                e_pc_en = 1'b1; e_pc_sel = 1'b1;
            end else if (s.rdy) begin
                e_pc_en = 1'b1; e_fd_en = 1'b1;
            end
        end else if (want) begin
            e_pc_en = 1'b1; e_pc_sel = 1'b1;
        end
    endtask

    task automatic model_step(input stim_t s);
        logic applied, done;
        applied = e_pc_en & e_pc_sel;
        done    = applied | e_fd_en;
        if (m_err) begin
            m_err = 1'b1;
        end else if (m_req) begin
            if (s.ack && done) begin
                m_req = !s.halt; m_wait = 0;
            end else if (s.ack) begin
                m_req = 1'b0; m_hold = 1'b1;
            end else if (m_wait == int'(TMO) - 1) begin
                m_req = 1'b0; m_err = 1'b1;
            end else begin
                m_wait++;
            end
        end else if (m_hold) begin
            if (done) begin
                m_hold = 1'b0; m_req = !s.halt; m_wait = 0;
            end
        end else if (s.start && !s.halt) begin
            m_req = 1'b1; m_wait = 0;
        end
        m_fdv  = s.redir ? 1'b0 : (e_fd_en ? 1'b1 : (s.rdy ? 1'b0 : m_fdv));
        m_cnt  = m_cnt + {15'd0, e_fd_en};
        m_tgt  = s.redir ? s.tgt : m_tgt;
        m_pend = applied ? 1'b0 : (s.redir ? 1'b1 : m_pend);
    endtask

    task automatic drive(input stim_t s);
        bus.i_start     = s.start;
        bus.i_halt      = s.halt;
        bus.i_imem_ack  = s.ack;
        bus.i_redirect  = s.redir;
        bus.i_pc_target = s.tgt;
        bus.i_fd_ready  = s.rdy;
    endtask

    task automatic check_model(input stim_t s);
        model_comb(s);
        chk("req",      {63'd0, bus.o_imem_req},    {63'd0, m_req});
        chk("fd_en",    {63'd0, bus.o_fd_en},       {63'd0, e_fd_en});
        chk("pc_en",    {63'd0, bus.o_pc_en},       {63'd0, e_pc_en});
        chk("pc_sel",   {63'd0, bus.o_pc_sel},      {63'd0, e_pc_sel});
        chk("flush",    {63'd0, bus.o_flush},       {63'd0, e_flush});
        chk("pc_tgt",   {32'd0, bus.o_pc_target},   {32'd0, e_tgt});
        chk("fd_valid", {63'd0, bus.o_fd_valid},    {63'd0, m_fdv});
        chk("err",      {63'd0, bus.o_err_timeout}, {63'd0, m_err});
        chk("cnt",      {48'd0, bus.o_fetch_cnt},   {48'd0, m_cnt});
    endtask

    task automatic advance(input stim_t s);
        @(posedge clk);
        model_step(s);
        #1;
    endtask

    task automatic run_cycle(input stim_t s);
        drive(s);
        #1;
        check_model(s);
        advance(s);
    endtask

    task automatic do_reset();
        drive(mks(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0));
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        stim_t s;
        // start, halt, ack, redir, tgt, rdy | req, fd_en, pc_en, pc_sel, fd_valid, cnt
        tbl[0] = mk(mks(1, 0, 0, 0, 32'd0, 0), 0, 0, 0, 0, 0, 16'd0);
        for (int k = 1; k <= 8; k++) begin
            tbl[k] = mk(mks(1, 0, 1, 0, 32'd0, 1), 1, 1, 1, 0, (k > 1), 16'(k - 1));
        end
        tbl[9]  = mk(mks(1, 0, 0, 0, 32'd0, 0), 1, 0, 0, 0, 1, 16'd8);
        tbl[10] = mk(mks(1, 0, 1, 0, 32'd0, 0), 1, 0, 0, 0, 1, 16'd8);
        tbl[11] = mk(mks(1, 0, 0, 0, 32'd0, 0), 0, 0, 0, 0, 1, 16'd8);
        tbl[12] = mk(mks(1, 0, 0, 0, 32'd0, 0), 0, 0, 0, 0, 1, 16'd8);
        tbl[13] = mk(mks(1, 0, 0, 0, 32'd0, 1), 0, 1, 1, 0, 1, 16'd8);
        tbl[14] = mk(mks(1, 0, 0, 0, 32'd0, 1), 1, 0, 0, 0, 1, 16'd9);
        tbl[15] = mk(mks(1, 0, 0, 1, 32'h0000_0100, 0), 1, 0, 0, 0, 0, 16'd9);
        tbl[16] = mk(mks(1, 0, 0, 0, 32'd0, 0), 1, 0, 0, 0, 0, 16'd9);
        tbl[17] = mk(mks(1, 0, 1, 0, 32'd0, 1), 1, 0, 1, 1, 0, 16'd9);
        tbl[18] = mk(mks(1, 0, 1, 0, 32'd0, 1), 1, 1, 1, 0, 0, 16'd9);
        tbl[19] = mk(mks(1, 0, 1, 1, 32'h0000_0200, 1), 1, 0, 1, 1, 1, 16'd10);
        tbl[20] = mk(mks(0, 1, 0, 0, 32'd0, 0), 1, 0, 0, 0, 0, 16'd10);
        tbl[21] = mk(mks(0, 1, 1, 0, 32'd0, 1), 1, 1, 1, 0, 0, 16'd10);
        tbl[22] = mk(mks(0, 1, 0, 0, 32'd0, 0), 0, 0, 0, 0, 1, 16'd11);
        tbl[23] = mk(mks(0, 0, 0, 0, 32'd0, 1), 0, 0, 0, 0, 1, 16'd11);
        tbl[24] = mk(mks(0, 0, 0, 0, 32'd0, 0), 0, 0, 0, 0, 0, 16'd11);

        rst_n = 1'b0;
        do_reset();

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].s);
            #1;
            chk("tbl_req",    {63'd0, bus.o_imem_req}, {63'd0, tbl[i].req});
            chk("tbl_fd_en",  {63'd0, bus.o_fd_en},    {63'd0, tbl[i].fd_en});
            chk("tbl_pc_en",  {63'd0, bus.o_pc_en},    {63'd0, tbl[i].pc_en});
            chk("tbl_pc_sel", {63'd0, bus.o_pc_sel},   {63'd0, tbl[i].pc_sel});
            chk("tbl_fdv",    {63'd0, bus.o_fd_valid}, {63'd0, tbl[i].fdv});
            chk("tbl_cnt",    {48'd0, bus.o_fetch_cnt}, {48'd0, tbl[i].cnt});
            if (i == 17) begin
                chk("tbl_squash_tgt", {32'd0, bus.o_pc_target}, 64'h0000_0100);
            end
            check_model(tbl[i].s);
            advance(tbl[i].s);
        end

        // Memory never acks: 16 REQ cycles, then sticky error with req low.
        do_reset();
        s = mks(1, 0, 0, 0, 32'd0, 0);
        run_cycle(s);
        for (int i = 0; i < int'(TMO); i++) begin
            drive(s);
            #1;
            chk("tmo_req_held", {63'd0, bus.o_imem_req},    64'd1);
            chk("tmo_no_err",   {63'd0, bus.o_err_timeout}, 64'd0);
            check_model(s);
            advance(s);
        end
        drive(s);
        #1;
        chk("tmo_err", {63'd0, bus.o_err_timeout}, 64'd1);
        chk("tmo_req", {63'd0, bus.o_imem_req},    64'd0);
        advance(s);
        for (int i = 0; i < 6; i++) begin
            run_cycle(mks(1, 0, 1, (i == 2), 32'h0000_0abc, 1));
        end
        rst_n = 1'b0;
        #1;
        chk("tmo_err_cleared", {63'd0, bus.o_err_timeout}, 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Async reset mid-REQ drops req without a clock edge; stray ack afterwards ignored.
        do_reset();
        run_cycle(mks(1, 0, 0, 0, 32'd0, 0));
        run_cycle(mks(1, 0, 0, 0, 32'd0, 0));
        drive(mks(0, 0, 0, 0, 32'd0, 0));
        chk("arst_req_before", {63'd0, bus.o_imem_req}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_req_drop", {63'd0, bus.o_imem_req}, 64'd0);
        model_reset();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_cycle(mks(0, 0, 1, 0, 32'd0, 1));
        for (int i = 0; i < 4; i++) begin
            run_cycle(mks(0, 0, 0, 0, 32'd0, 0));
        end

        // Randomized traffic; the last block starves acks to reach the timeout.
        for (int blk = 0; blk < 6; blk++) begin
            do_reset();
            for (int i = 0; i < 500; i++) begin
                s.start = ($urandom_range(0, 9) != 0);
                s.halt  = ($urandom_range(0, 15) == 0);
                if (blk == 5) begin
                    s.ack = m_req && ($urandom_range(0, 7) == 0);
                end else begin
                    s.ack = m_req && ($urandom_range(0, 3) != 0);
                end
                s.redir = ($urandom_range(0, 7) == 0);
                s.tgt   = $urandom;
                s.rdy   = ($urandom_range(0, 1) == 1);
                run_cycle(s);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/ariscv_fetch_ctrl.md
# ariscv_fetch_ctrl

Sequencing controller for the fetch stage of the asynchronous RISC-V pipeline. It runs the req/ack handshake with instruction memory and generates the PC-register and fetch/decode-register capture enables. It also handles back-pressure from decode and redirects from execute, latching the redirect target until the PC register consumes it. It sits between instruction memory, the fetch datapath (PC mux, PC register, FD register) and the decode/execute stages.

## Interface
- NBW_PC, 32, PC/target width
- NBW_CNT, 16, width of delivered-instruction counter
- TMO_CYCLES, 16, max cycles in REQ without ack before error; 0 disables timeout
- pc_aclk  in  1  clock; all state on rising edge
- rst_async_n  in  1  reset, asynchronous, active-low
- i_start  in  1  level; enables fetching from IDLE
- i_halt  in  1  level; stop issuing new requests
- o_imem_req  out  1  registered instruction-memory request
- i_imem_ack  in  1  one-cycle pulse; i_inst valid this cycle and held until next req transaction
- i_redirect  in  1  one-cycle pulse from execute (taken branch/jump)
- i_pc_target  in  NBW_PC  redirect target, valid with i_redirect
- o_pc_en  out  1  combinational; PC register load enable
- o_pc_sel  out  1  combinational; 1 = load o_pc_target, 0 = load PC+4
- o_pc_target  out  NBW_PC  i_redirect ? i_pc_target : tgt_ff
- o_fd_en  out  1  combinational; FD register capture enable
- o_fd_valid  out  1  registered; FD register holds a live instruction
- i_fd_ready  in  1  decode consumes FD contents this cycle
- o_flush  out  1  combinational; equals i_redirect, FD contents squashed
- o_err_timeout  out  1  sticky memory-timeout flag
- o_fetch_cnt  out  NBW_CNT  instructions delivered to FD, wraps modulo 2^NBW_CNT

## Operation
- States: IDLE, REQ, WAIT_FD, ERR. o_imem_req = (state == REQ).
- pend_ff: redirect pending. tgt_ff: latched target. On i_redirect, tgt_ff <= i_pc_target. pend_ff is set on i_redirect unless the redirect is applied that same cycle; it clears when the redirect is applied.
- Redirect applied (o_pc_en=1, o_pc_sel=1):
  - in IDLE or WAIT_FD, on i_redirect or pend_ff, immediately;
  - in REQ, on the ack cycle ("squash ack").
- IDLE: i_start & !i_halt -> REQ.
- REQ, ack cycle, squash (pend_ff | i_redirect): discard instruction, o_fd_en=0, redirect applied; next REQ, or IDLE if i_halt.
- REQ, ack cycle, no squash, slot free (!o_fd_valid | i_fd_ready): o_fd_en=1, o_pc_en=1, o_pc_sel=0; next REQ, or IDLE if i_halt.
- REQ, ack cycle, no squash, slot busy: -> WAIT_FD.
- WAIT_FD:
  - i_redirect or pend_ff: apply redirect, discard held instruction, -> REQ (IDLE if i_halt);
  - else i_fd_ready: o_fd_en=1, o_pc_en=1, o_pc_sel=0, -> REQ (IDLE if i_halt).
- o_fd_valid next:
  - 0 if i_redirect;
  - else 1 if o_fd_en;
  - else 0 if i_fd_ready;
  - else hold.
- Timeout counter clears on REQ entry and increments each REQ cycle without ack. When it reaches TMO_CYCLES-1 with no ack -> ERR.
- ERR: req=0, all enables 0, o_err_timeout=1. Exits only via reset.
- o_fetch_cnt increments on every o_fd_en.

## Timing
- Reset (async, immediate): state IDLE, o_imem_req 0, o_fd_valid 0, o_err_timeout 0, o_fetch_cnt 0, tgt_ff 0, pend_ff 0. Combinational outputs are 0 absent i_redirect.
- Reset mid-transaction drops o_imem_req asynchronously; any outstanding ack after reset release is ignored in IDLE.
- i_start at cycle n in IDLE -> o_imem_req=1 at n+1.
- Ack at cycle m -> o_fd_en/o_pc_en asserted in cycle m, o_fd_valid=1 at m+1. o_imem_req stays high at m+1 for back-to-back fetch.
- Throughput is 1 instruction/cycle when ack arrives each cycle and decode is ready.
- Redirect in the same cycle as a free-slot ack: squash wins, no FD capture.
- Redirect in the same cycle as decode consume: flush wins; o_fd_valid=0 next cycle.
- i_halt during REQ: the current transaction completes, then IDLE. No request is ever abandoned.

## Test plan
- Reset, i_start=1, ack every cycle, i_fd_ready=1 -> req at cycle 1. o_fd_en/o_pc_en (sel 0) every cycle. o_fetch_cnt=8 after 8 acks.
- i_fd_ready=0 with o_fd_valid=1, ack arrives -> WAIT_FD, req=0, no o_fd_en. Raise i_fd_ready 3 cycles later -> o_fd_en and o_pc_en in that cycle, req high next cycle.
- i_redirect with i_pc_target=0x0000_0100 two cycles before ack -> o_flush pulse, o_fd_valid=0 next. On ack: o_pc_en=1, o_pc_sel=1, o_pc_target=0x100, o_fd_en=0, o_fetch_cnt unchanged.
- i_redirect coincident with ack and with i_fd_ready -> no o_fd_en, o_pc_sel=1, o_fd_valid=0 next cycle.
- TMO_CYCLES=16, no ack -> o_err_timeout=1 after 16 REQ cycles, req=0. Sticky until rst_async_n low clears to IDLE.
- Assert rst_async_n=0 mid-REQ -> o_imem_req falls immediately. After release with i_start=0, stays IDLE with all outputs at reset values.
